// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_unit_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } ibuf_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Small synchronous first-word-fall-through FIFO; head entry is visible while non-empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full, wr_en, rd_en;
  logic [DEPTH-1:0] wr_sel;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign rd_en    = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push.
  assign wr_en    = push && (!full || rd_en);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) mem_reg[i] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (rd_en) rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-limited memory requests, in-order response
// pairing with request PCs, and redirect flushing of stale in-flight responses.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int ZW = CW + 1;
  localparam int EW = $bits(ibuf_entry_t);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   discard_reg, discard_next;

  logic            pend_empty;
  logic [CW-1:0]   pend_count;
  logic [XLEN-1:0] pend_pc;
  logic            ibuf_empty;
  logic [CW-1:0]   ibuf_count;
  logic [EW-1:0]   ibuf_raw;
  ibuf_entry_t     ibuf_head, ibuf_in;

  logic [ZW-1:0]   outstanding, used;
  logic            req_valid, req_fire, rsp_ret, rsp_keep, inst_avail, inst_pop;

  // Every in-flight request is either awaiting pairing in the PC queue or marked for discard.
  assign outstanding = ZW'(pend_count) + ZW'(discard_reg);
  assign rsp_ret     = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep    = rsp_ret && (state_reg == FETCH) && !redirect_valid && !pend_empty;
  assign inst_avail  = rst_n && !ibuf_empty;
  assign inst_pop    = inst_avail && inst_ready;
  // A buffer slot being consumed this cycle counts as free, which sustains one fetch per cycle.
  assign used        = outstanding + ZW'(ibuf_count) - ZW'(inst_pop);
  assign req_valid   = rst_n && (state_reg == FETCH) && !redirect_valid && (used < ZW'(DEPTH));
  assign req_fire    = req_valid && imem_req_ready;

  assign ibuf_in   = '{pc: pend_pc, data: imem_rsp_data};
  assign ibuf_head = ibuf_entry_t'(ibuf_raw);

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .pop_data  (pend_pc),
    .empty     (pend_empty),
    .count     (pend_count)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (rsp_keep),
    .push_data (ibuf_in),
    .pop       (inst_pop),
    .pop_data  (ibuf_raw),
    .empty     (ibuf_empty),
    .count     (ibuf_count)
  );

  always_comb begin
    pc_next      = pc_reg;
    state_next   = state_reg;
    discard_next = discard_reg;
    if (req_fire) pc_next = pc_reg + PC_STEP;
    if (redirect_valid) begin
      // A response landing in the redirect cycle is dropped now, so it is not counted.
      pc_next      = align_word(redirect_pc);
      discard_next = CW'(outstanding - ZW'(rsp_ret));
      state_next   = (discard_next != '0) ? FLUSH : FETCH;
    end else if (state_reg == FLUSH) begin
      if (rsp_ret) discard_next = discard_reg - CW'(1);
      if (discard_next == '0) state_next = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      state_reg   <= FETCH;
      discard_reg <= '0;
    end else begin
      pc_reg      <= pc_next;
      state_reg   <= state_next;
      discard_reg <= discard_next;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = rst_n ? pc_reg : RESET_PC;
  assign inst_valid     = inst_avail;
  assign instruction    = inst_avail ? ibuf_head.data : NOP_INSN;
  assign inst_pc        = inst_avail ? ibuf_head.pc : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and random checks of ifetch_unit against an in-order instruction stream model.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] cons_pc_q[$];
  int          cons_cyc_q[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1;
  int          n_assert = 0, n_fail = 0;
  int          fire_count = 0, cons_count = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  bit          cur_fire, cur_req_valid, cur_inst_valid;
  logic [31:0] cur_fire_addr, cur_req_addr, cur_instr, cur_inst_pc;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: memory model drives its response, outputs are sampled and checked.
  task automatic tick();
    mreq_t e;
    int    lat;
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = img(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    cur_fire       = 0;
    cur_req_valid  = imem_req_valid;
    cur_req_addr   = imem_req_addr;
    cur_inst_valid = inst_valid;
    cur_instr      = instruction;
    cur_inst_pc    = inst_pc;
    if (!rst_n) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_instruction", instruction, NOP_INSN);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      prev_stall = 0;
      exp_pc     = RESET_PC;
      last_due   = 0;
    end else begin
      if (prev_stall && !redirect_valid) begin
        chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
        chk("hold_req_addr", imem_req_addr, prev_addr);
      end
      if (redirect_valid) chk("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      if (inst_valid && inst_ready) begin
        chk("stream_pc", inst_pc, exp_pc);
        chk("stream_insn", instruction, img(exp_pc));
        cons_pc_q.push_back(inst_pc);
        cons_cyc_q.push_back(cyc);
        cons_count++;
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
        cur_fire      = 1;
        cur_fire_addr = imem_req_addr;
        fire_count++;
        lat    = $urandom_range(lat_max, lat_min);
        e.addr = imem_req_addr;
        e.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = e.due;
        mq.push_back(e);
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr  = imem_req_addr;
      if (imem_rsp_valid) void'(mq.pop_front());
      chk("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int          base, n0, fc0, guard;
    logic [31:0] first_pc;

    // Reset release, latency 1: contiguous stream, one instruction per cycle after the first.
    inst_ready = 1'b1;
    do_reset(3);
    base = cyc;
    cons_pc_q.delete();
    cons_cyc_q.delete();
    repeat (8) tick();
    chk("seq_have_four", 32'(cons_pc_q.size() >= 4), 32'd1);
    if (cons_pc_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("seq_pc", cons_pc_q[k], 32'(4 * k));
        chk("seq_cycle", 32'(cons_cyc_q[k] - base), 32'(2 + k));
      end
    end

    // Decoder stalled: credits stop fetching after DEPTH requests.
    do_reset(2);
    inst_ready = 1'b0;
    fc0 = fire_count;
    repeat (6) tick();
    chk("credit_fires", 32'(fire_count - fc0), 32'(DEPTH));
    chk("credit_stop_valid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    tick();
    chk("credit_resume_fire", 32'(cur_fire), 32'd1);
    chk("credit_resume_addr", cur_fire_addr, 32'h8);

    // Memory back-pressure at 0x10.
    do_reset(2);
    guard = 0;
    while (imem_req_addr != 32'h10 && guard < 40) begin
      tick();
      guard++;
    end
    chk("stall_reach_0x10", imem_req_addr, 32'h10);
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_valid", 32'(cur_req_valid), 32'd1);
      chk("stall_addr", cur_req_addr, 32'h10);
    end
    imem_req_ready = 1'b1;
    tick();
    chk("stall_fire_0x10", cur_fire ? cur_fire_addr : 32'hDEAD_BEEF, 32'h10);
    tick();
    chk("stall_fire_0x14", cur_fire ? cur_fire_addr : 32'hDEAD_BEEF, 32'h14);

    // Redirect with two responses in flight.
    do_reset(2);
    lat_min = 3;
    lat_max = 3;
    repeat (2) tick();
    chk("inflight_before_redirect", 32'(mq.size()), 32'd2);
    do_redirect(32'h103);
    repeat (3) begin
      tick();
      chk("flush_inst_valid", 32'(cur_inst_valid), 32'd0);
    end
    n0 = cons_pc_q.size();
    guard = 0;
    while (cons_pc_q.size() == n0 && guard < 20) begin
      tick();
      guard++;
    end
    first_pc = (cons_pc_q.size() > n0) ? cons_pc_q[n0] : 32'hDEAD_BEEF;
    chk("redirect_first_pc", first_pc, 32'h100);

    // PC wrap at the top of the address space.
    do_reset(2);
    lat_min = 1;
    lat_max = 1;
    do_redirect(32'hFFFF_FFFE);
    tick();
    chk("wrap_fire_top", cur_fire ? cur_fire_addr : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    tick();
    chk("wrap_fire_zero", cur_fire ? cur_fire_addr : 32'hDEAD_BEEF, 32'h0);
    repeat (4) tick();

    // Reset while flushing.
    do_reset(2);
    lat_min = 3;
    lat_max = 3;
    repeat (2) tick();
    do_redirect(32'h200);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_flush_inst_valid", 32'(cur_inst_valid), 32'd0);
    chk("rst_flush_instruction", cur_instr, NOP_INSN);
    chk("rst_flush_inst_pc", cur_inst_pc, 32'd0);
    chk("rst_flush_fire_addr", cur_fire ? cur_fire_addr : 32'hDEAD_BEEF, RESET_PC);
    repeat (6) tick();

    // Random traffic against the stream model.
    lat_min = 1;
    lat_max = 4;
    n0 = cons_count;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(9, 0) < 7);
      redirect_pc    = $urandom;
      redirect_valid = ($urandom_range(39, 0) == 0);
      if ($urandom_range(299, 0) == 0) do_reset(1);
      else tick();
    end
    redirect_valid = 1'b0;
    chk("random_progress", 32'(cons_count - n0 > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
